uart_rx_framer: RTL and testbench

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx_framer.sv | 129 ++++++++++++
 tb/tb_uart_rx_framer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  localparam int unsigned OVS_DEFAULT = 16;

  // Tick index at the centre of the start bit for a given oversampling ratio.
  function automatic int unsigned mid_tick_of(input int unsigned ovs);
    return ovs / 2 - 1;
  endfunction

  localparam int unsigned MID_TICK = OVS_DEFAULT / 2 - 1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the raw line through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: oversampled start/data/stop detection with a one-word holding register
// and sticky frame/overrun error flags.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OVS       = OVS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 UxRX,
  input  logic                 rd_en,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 UxRXIF,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int unsigned TW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TickLast = TW'(OVS - 1);
  localparam logic [TW-1:0] TickMid  = TW'(mid_tick_of(OVS));
  localparam logic [BW-1:0] BitLast  = BW'(DATA_BITS - 1);

  logic rxs;

  rx_state_e            state_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rxif_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (UxRX),
    .q   (rxs)
  );

  // Receive FSM, holding register and sticky flags. Later assignments in this block take
  // priority: an error set beats err_clr, and a completion load beats a same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rxif_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (rd_en && rxif_q) begin
        rxif_q <= 1'b0;
      end
      if (err_clr) begin
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      if (baud_tick) begin
        unique case (state_q)
          StIdle: begin
            if (!rxs) begin
              state_q <= StStart;
              tick_q  <= '0;
            end
          end
          StStart: begin
            if (tick_q == TickMid) begin
              tick_q  <= '0;
              bit_q   <= '0;
              // A high line at the start-bit centre was only a glitch.
              state_q <= rxs ? StIdle : StData;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          StData: begin
            if (tick_q == TickLast) begin
              tick_q  <= '0;
              shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
              if (bit_q == BitLast) begin
                bit_q   <= '0;
                state_q <= StStop;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          StStop: begin
            if (tick_q == TickLast) begin
              // Return at the stop-bit centre so a following start edge is not missed.
              tick_q  <= '0;
              state_q <= StIdle;
              if (!rxs) begin
                frame_err_q <= 1'b1;
              end
              if (rxif_q && !rd_en) begin
                overrun_q <= 1'b1;
              end else begin
                rx_data_q <= shift_q;
                rxif_q    <= 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign UxRXIF      = rxif_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign rx_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: baud_tick every 4 clk, 16 ticks per bit, 8 data bits.
module tb_uart_rx_framer;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       UxRX;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       UxRXIF;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_data;
  logic       got_flag;
  logic       got_ferr;
  logic       got_busy_mid;

  uart_rx_framer #(
    .DATA_BITS (8),
    .OVS       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .UxRX        (UxRX),
    .rd_en       (rd_en),
    .err_clr     (err_clr),
    .rx_data     (rx_data),
    .UxRXIF      (UxRXIF),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Exactly one baud_tick in every four clocks, changed on the falling edge.
  initial begin
    int div;
    div       = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      div       = (div + 1) % 4;
      baud_tick = (div == 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns 1 ns after the clock edge that consumed the n-th baud tick.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  // rd_mode: 0 no read, 1 read on the stop-sample clock, 2 read right after completion.
  task automatic send_frame(input logic [7:0] data, input logic stop_val, input int rd_mode);
    UxRX = 1'b0;
    wait_ticks(16);
    for (int b = 0; b < 8; b++) begin
      UxRX = data[b];
      wait_ticks(16);
      if (b == 0) got_busy_mid = rx_busy;
    end
    UxRX = stop_val;
    wait_ticks(8);
    if (rd_mode == 1) begin
      repeat (3) @(posedge clk);
      #1 rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
    end else begin
      wait_ticks(1);
    end
    got_data = rx_data;
    got_flag = UxRXIF;
    got_ferr = frame_err;
    if (rd_mode == 2) pulse_rd();
    wait_ticks(7);
    UxRX = 1'b1;
  endtask

  initial begin
    rst     = 1'b1;
    UxRX    = 1'b1;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("reset rx_data", rx_data, 8'h00);
    check_eq("reset UxRXIF", UxRXIF, 1'b0);
    check_eq("reset frame_err", frame_err, 1'b0);
    check_eq("reset overrun_err", overrun_err, 1'b0);
    check_eq("reset rx_busy", rx_busy, 1'b0);

    // Clean frame
    wait_ticks(2);
    send_frame(8'hA5, 1'b1, 0);
    check_eq("a5 busy mid-frame", got_busy_mid, 1'b1);
    check_eq("a5 rx_data", rx_data, 8'hA5);
    check_eq("a5 UxRXIF", UxRXIF, 1'b1);
    check_eq("a5 frame_err", frame_err, 1'b0);
    check_eq("a5 rx_busy after stop", rx_busy, 1'b0);
    pulse_rd();
    check_eq("pop UxRXIF", UxRXIF, 1'b0);
    check_eq("pop rx_data held", rx_data, 8'hA5);
    pulse_rd();
    check_eq("empty pop UxRXIF", UxRXIF, 1'b0);
    check_eq("empty pop rx_data", rx_data, 8'hA5);

    // Short low glitch is rejected at the start-bit centre
    wait_ticks(1);
    UxRX = 1'b0;
    wait_ticks(3);
    UxRX = 1'b1;
    check_eq("glitch busy in start", rx_busy, 1'b1);
    wait_ticks(12);
    check_eq("glitch back to idle", rx_busy, 1'b0);
    check_eq("glitch UxRXIF", UxRXIF, 1'b0);

    // Stop bit low
    wait_ticks(1);
    send_frame(8'h3C, 1'b0, 0);
    wait_ticks(20);
    check_eq("3c rx_data", rx_data, 8'h3C);
    check_eq("3c UxRXIF", UxRXIF, 1'b1);
    check_eq("3c frame_err", frame_err, 1'b1);
    check_eq("3c idle after false start", rx_busy, 1'b0);
    pulse_clr();
    check_eq("3c frame_err cleared", frame_err, 1'b0);
    pulse_rd();

    // Overrun: second word dropped
    wait_ticks(1);
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    check_eq("overrun rx_data kept", rx_data, 8'h11);
    check_eq("overrun flag", overrun_err, 1'b1);
    check_eq("overrun UxRXIF", UxRXIF, 1'b1);
    pulse_clr();
    check_eq("overrun cleared", overrun_err, 1'b0);
    pulse_rd();

    // Read on the completion cycle lets the new word in
    wait_ticks(1);
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 1);
    check_eq("rd+done rx_data", rx_data, 8'h22);
    check_eq("rd+done UxRXIF", UxRXIF, 1'b1);
    check_eq("rd+done overrun", overrun_err, 1'b0);

    // Reset in the 4th data bit of 0xFF
    wait_ticks(1);
    UxRX = 1'b0;
    wait_ticks(16);
    UxRX = 1'b1;
    wait_ticks(56);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_eq("midrst rx_data", rx_data, 8'h00);
    check_eq("midrst UxRXIF", UxRXIF, 1'b0);
    check_eq("midrst frame_err", frame_err, 1'b0);
    check_eq("midrst overrun_err", overrun_err, 1'b0);
    check_eq("midrst rx_busy", rx_busy, 1'b0);
    wait_ticks(120);
    check_eq("midrst no late flag", UxRXIF, 1'b0);
    send_frame(8'h5A, 1'b1, 0);
    check_eq("5a rx_data", rx_data, 8'h5A);
    check_eq("5a UxRXIF", UxRXIF, 1'b1);
    check_eq("5a frame_err", frame_err, 1'b0);
    pulse_rd();

    // Back-to-back frames with no idle gap
    wait_ticks(1);
    send_frame(8'h81, 1'b1, 2);
    check_eq("b2b first word", got_data, 8'h81);
    check_eq("b2b first flag", got_flag, 1'b1);
    send_frame(8'h7E, 1'b1, 2);
    check_eq("b2b second word", got_data, 8'h7E);
    check_eq("b2b second flag", got_flag, 1'b1);
    check_eq("b2b frame_err", got_ferr, 1'b0);
    check_eq("b2b overrun", overrun_err, 1'b0);
    check_eq("b2b UxRXIF after reads", UxRXIF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
